// File: rtl/axi_acp_bridge_pipelined.sv
// AXI3 bridge from a fabric master to the HPS F2S port for ACP accesses: skid-buffered
// AR/AW with cache/prot/user conditioning, outstanding limits and sticky error flags.

module axi_acp_cmd_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] head,
   output logic         nonempty,
   input  logic         pop
);
   logic [W-1:0] mem_reg [2];
   logic         wr_ptr_reg, rd_ptr_reg, ready_reg;
   logic [1:0]   count_reg, count_next;
   logic         push, pop_ok;

   assign push       = in_valid & ready_reg;
   assign pop_ok     = pop & (count_reg != 2'd0);
   assign count_next = count_reg + 2'(push) - 2'(pop_ok);
   assign in_ready   = ready_reg;
   assign nonempty   = (count_reg != 2'd0);
   assign head       = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) mem_reg[wr_ptr_reg] <= in_data;
   end

   // ready depends only on registered occupancy, so m0 ready never reaches s0 ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
         ready_reg  <= 1'b1;
      end else begin
         if (push)   wr_ptr_reg <= ~wr_ptr_reg;
         if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_next;
         ready_reg <= (count_next < 2'd2);
      end
   end
endmodule

module axi_acp_bridge_pipelined #(
   parameter int                    DATA_WIDTH  = 128,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    ID_WIDTH    = 8,
   parameter int                    USER_WIDTH  = 5,
   parameter bit                    OVERRIDE_EN = 1'b1,
   parameter logic [3:0]            AXCACHE_VAL = 4'b1111,
   parameter logic [2:0]            AXPROT_VAL  = 3'b000,
   parameter logic [USER_WIDTH-1:0] AXUSER_VAL  = USER_WIDTH'(1),
   parameter int                    MAX_RD      = 4,
   parameter int                    MAX_WR      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   axs_s0_araddr,
   input  logic [1:0]              axs_s0_arburst,
   input  logic [3:0]              axs_s0_arcache,
   input  logic [ID_WIDTH-1:0]     axs_s0_arid,
   input  logic [3:0]              axs_s0_arlen,
   input  logic [1:0]              axs_s0_arlock,
   input  logic [2:0]              axs_s0_arprot,
   input  logic [2:0]              axs_s0_arsize,
   input  logic [USER_WIDTH-1:0]   axs_s0_aruser,
   input  logic                    axs_s0_arvalid,
   output logic                    axs_s0_arready,
   input  logic [ADDR_WIDTH-1:0]   axs_s0_awaddr,
   input  logic [1:0]              axs_s0_awburst,
   input  logic [3:0]              axs_s0_awcache,
   input  logic [ID_WIDTH-1:0]     axs_s0_awid,
   input  logic [3:0]              axs_s0_awlen,
   input  logic [1:0]              axs_s0_awlock,
   input  logic [2:0]              axs_s0_awprot,
   input  logic [2:0]              axs_s0_awsize,
   input  logic [USER_WIDTH-1:0]   axs_s0_awuser,
   input  logic                    axs_s0_awvalid,
   output logic                    axs_s0_awready,
   input  logic [DATA_WIDTH-1:0]   axs_s0_wdata,
   input  logic [ID_WIDTH-1:0]     axs_s0_wid,
   input  logic                    axs_s0_wlast,
   input  logic [DATA_WIDTH/8-1:0] axs_s0_wstrb,
   input  logic                    axs_s0_wvalid,
   output logic                    axs_s0_wready,
   output logic [DATA_WIDTH-1:0]   axs_s0_rdata,
   output logic [ID_WIDTH-1:0]     axs_s0_rid,
   output logic                    axs_s0_rlast,
   output logic [1:0]              axs_s0_rresp,
   output logic                    axs_s0_rvalid,
   input  logic                    axs_s0_rready,
   output logic [ID_WIDTH-1:0]     axs_s0_bid,
   output logic [1:0]              axs_s0_bresp,
   output logic                    axs_s0_bvalid,
   input  logic                    axs_s0_bready,
   output logic [ADDR_WIDTH-1:0]   axm_m0_araddr,
   output logic [1:0]              axm_m0_arburst,
   output logic [3:0]              axm_m0_arcache,
   output logic [ID_WIDTH-1:0]     axm_m0_arid,
   output logic [3:0]              axm_m0_arlen,
   output logic [1:0]              axm_m0_arlock,
   output logic [2:0]              axm_m0_arprot,
   output logic [2:0]              axm_m0_arsize,
   output logic [USER_WIDTH-1:0]   axm_m0_aruser,
   output logic                    axm_m0_arvalid,
   input  logic                    axm_m0_arready,
   output logic [ADDR_WIDTH-1:0]   axm_m0_awaddr,
   output logic [1:0]              axm_m0_awburst,
   output logic [3:0]              axm_m0_awcache,
   output logic [ID_WIDTH-1:0]     axm_m0_awid,
   output logic [3:0]              axm_m0_awlen,
   output logic [1:0]              axm_m0_awlock,
   output logic [2:0]              axm_m0_awprot,
   output logic [2:0]              axm_m0_awsize,
   output logic [USER_WIDTH-1:0]   axm_m0_awuser,
   output logic                    axm_m0_awvalid,
   input  logic                    axm_m0_awready,
   output logic [DATA_WIDTH-1:0]   axm_m0_wdata,
   output logic [ID_WIDTH-1:0]     axm_m0_wid,
   output logic                    axm_m0_wlast,
   output logic [DATA_WIDTH/8-1:0] axm_m0_wstrb,
   output logic                    axm_m0_wvalid,
   input  logic                    axm_m0_wready,
   input  logic [DATA_WIDTH-1:0]   axm_m0_rdata,
   input  logic [ID_WIDTH-1:0]     axm_m0_rid,
   input  logic                    axm_m0_rlast,
   input  logic [1:0]              axm_m0_rresp,
   input  logic                    axm_m0_rvalid,
   output logic                    axm_m0_rready,
   input  logic [ID_WIDTH-1:0]     axm_m0_bid,
   input  logic [1:0]              axm_m0_bresp,
   input  logic                    axm_m0_bvalid,
   output logic                    axm_m0_bready,
   output logic [3:0]              rd_outstanding,
   output logic [3:0]              wr_outstanding,
   output logic                    idle,
   output logic [1:0]              protocol_err
);
   localparam int CW = ADDR_WIDTH + ID_WIDTH + USER_WIDTH + 18;

   logic [CW-1:0]         ar_head, aw_head;
   logic                  ar_nonempty, aw_nonempty, ar_hs, aw_hs, r_done, b_done;
   logic [3:0]            ar_cache_buf, aw_cache_buf;
   logic [2:0]            ar_prot_buf, aw_prot_buf;
   logic [USER_WIDTH-1:0] ar_user_buf, aw_user_buf;
   logic [3:0]            rd_cnt_reg, wr_cnt_reg;
   logic [1:0]            err_reg;

   axi_acp_cmd_skid #(.W(CW)) u_ar_skid (
      .clk(clk), .reset(reset),
      .in_data({axs_s0_araddr, axs_s0_arburst, axs_s0_arcache, axs_s0_arid, axs_s0_arlen,
                axs_s0_arlock, axs_s0_arprot, axs_s0_arsize, axs_s0_aruser}),
      .in_valid(axs_s0_arvalid), .in_ready(axs_s0_arready),
      .head(ar_head), .nonempty(ar_nonempty), .pop(ar_hs)
   );

   axi_acp_cmd_skid #(.W(CW)) u_aw_skid (
      .clk(clk), .reset(reset),
      .in_data({axs_s0_awaddr, axs_s0_awburst, axs_s0_awcache, axs_s0_awid, axs_s0_awlen,
                axs_s0_awlock, axs_s0_awprot, axs_s0_awsize, axs_s0_awuser}),
      .in_valid(axs_s0_awvalid), .in_ready(axs_s0_awready),
      .head(aw_head), .nonempty(aw_nonempty), .pop(aw_hs)
   );

   assign {axm_m0_araddr, axm_m0_arburst, ar_cache_buf, axm_m0_arid, axm_m0_arlen,
           axm_m0_arlock, ar_prot_buf, axm_m0_arsize, ar_user_buf} = ar_head;
   assign {axm_m0_awaddr, axm_m0_awburst, aw_cache_buf, axm_m0_awid, axm_m0_awlen,
           axm_m0_awlock, aw_prot_buf, axm_m0_awsize, aw_user_buf} = aw_head;

   assign axm_m0_arcache = OVERRIDE_EN ? AXCACHE_VAL : ar_cache_buf;
   assign axm_m0_arprot  = OVERRIDE_EN ? AXPROT_VAL  : ar_prot_buf;
   assign axm_m0_aruser  = OVERRIDE_EN ? AXUSER_VAL  : ar_user_buf;
   assign axm_m0_awcache = OVERRIDE_EN ? AXCACHE_VAL : aw_cache_buf;
   assign axm_m0_awprot  = OVERRIDE_EN ? AXPROT_VAL  : aw_prot_buf;
   assign axm_m0_awuser  = OVERRIDE_EN ? AXUSER_VAL  : aw_user_buf;

   // valid only rises when a slot is free, and only its own handshake consumes the slot
   assign axm_m0_arvalid = ar_nonempty & (rd_cnt_reg < 4'(MAX_RD));
   assign axm_m0_awvalid = aw_nonempty & (wr_cnt_reg < 4'(MAX_WR));
   assign ar_hs  = axm_m0_arvalid & axm_m0_arready;
   assign aw_hs  = axm_m0_awvalid & axm_m0_awready;
   assign r_done = axm_m0_rvalid & axs_s0_rready & axm_m0_rlast;
   assign b_done = axm_m0_bvalid & axs_s0_bready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt_reg <= 4'd0;
         wr_cnt_reg <= 4'd0;
         err_reg    <= 2'b00;
      end else begin
         if (r_done && rd_cnt_reg == 4'd0) err_reg[0] <= 1'b1;
         if (b_done && wr_cnt_reg == 4'd0) err_reg[1] <= 1'b1;
         rd_cnt_reg <= rd_cnt_reg + 4'(ar_hs) - 4'(r_done && rd_cnt_reg != 4'd0);
         wr_cnt_reg <= wr_cnt_reg + 4'(aw_hs) - 4'(b_done && wr_cnt_reg != 4'd0);
      end
   end

   assign rd_outstanding = rd_cnt_reg;
   assign wr_outstanding = wr_cnt_reg;
   assign protocol_err   = err_reg;
   assign idle = ~ar_nonempty & ~aw_nonempty & (rd_cnt_reg == 4'd0) & (wr_cnt_reg == 4'd0);

   assign axm_m0_wdata  = axs_s0_wdata;
   assign axm_m0_wid    = axs_s0_wid;
   assign axm_m0_wlast  = axs_s0_wlast;
   assign axm_m0_wstrb  = axs_s0_wstrb;
   assign axm_m0_wvalid = axs_s0_wvalid;
   assign axs_s0_wready = axm_m0_wready;
   assign axs_s0_rdata  = axm_m0_rdata;
   assign axs_s0_rid    = axm_m0_rid;
   assign axs_s0_rlast  = axm_m0_rlast;
   assign axs_s0_rresp  = axm_m0_rresp;
   assign axs_s0_rvalid = axm_m0_rvalid;
   assign axm_m0_rready = axs_s0_rready;
   assign axs_s0_bid    = axm_m0_bid;
   assign axs_s0_bresp  = axm_m0_bresp;
   assign axs_s0_bvalid = axm_m0_bvalid;
   assign axm_m0_bready = axs_s0_bready;
endmodule

// File: tb/tb_axi_acp_bridge_pipelined.sv
// Bench for axi_acp_bridge_pipelined: queue-based command model checked every cycle on the
// default build, plus directed checks of a pass-through (OVERRIDE_EN=0, 64-bit) build.

module tb_axi_acp_bridge_pipelined;
   localparam int MAX_RD = 4, MAX_WR = 4;

   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- default build signals ----------------
   logic [31:0] s0_araddr, m0_araddr, s0_awaddr, m0_awaddr;
   logic [1:0]  s0_arburst, m0_arburst, s0_awburst, m0_awburst;
   logic [3:0]  s0_arcache, m0_arcache, s0_awcache, m0_awcache;
   logic [7:0]  s0_arid, m0_arid, s0_awid, m0_awid;
   logic [3:0]  s0_arlen, m0_arlen, s0_awlen, m0_awlen;
   logic [1:0]  s0_arlock, m0_arlock, s0_awlock, m0_awlock;
   logic [2:0]  s0_arprot, m0_arprot, s0_awprot, m0_awprot;
   logic [2:0]  s0_arsize, m0_arsize, s0_awsize, m0_awsize;
   logic [4:0]  s0_aruser, m0_aruser, s0_awuser, m0_awuser;
   logic        s0_arvalid, s0_arready, m0_arvalid, m0_arready;
   logic        s0_awvalid, s0_awready, m0_awvalid, m0_awready;
   logic [127:0] s0_wdata, m0_wdata, s0_rdata, m0_rdata;
   logic [15:0] s0_wstrb, m0_wstrb;
   logic [7:0]  s0_wid, m0_wid, s0_rid, m0_rid, s0_bid, m0_bid;
   logic        s0_wlast, m0_wlast, s0_wvalid, m0_wvalid, s0_wready, m0_wready;
   logic        s0_rlast, m0_rlast, s0_rvalid, m0_rvalid, s0_rready, m0_rready;
   logic [1:0]  s0_rresp, m0_rresp, s0_bresp, m0_bresp;
   logic        s0_bvalid, m0_bvalid, s0_bready, m0_bready;
   logic [3:0]  rd_out, wr_out;
   logic        idle;
   logic [1:0]  perr;

   axi_acp_bridge_pipelined #(.MAX_RD(MAX_RD), .MAX_WR(MAX_WR)) dut (
      .clk(clk), .reset(reset),
      .axs_s0_araddr(s0_araddr), .axs_s0_arburst(s0_arburst), .axs_s0_arcache(s0_arcache),
      .axs_s0_arid(s0_arid), .axs_s0_arlen(s0_arlen), .axs_s0_arlock(s0_arlock),
      .axs_s0_arprot(s0_arprot), .axs_s0_arsize(s0_arsize), .axs_s0_aruser(s0_aruser),
      .axs_s0_arvalid(s0_arvalid), .axs_s0_arready(s0_arready),
      .axs_s0_awaddr(s0_awaddr), .axs_s0_awburst(s0_awburst), .axs_s0_awcache(s0_awcache),
      .axs_s0_awid(s0_awid), .axs_s0_awlen(s0_awlen), .axs_s0_awlock(s0_awlock),
      .axs_s0_awprot(s0_awprot), .axs_s0_awsize(s0_awsize), .axs_s0_awuser(s0_awuser),
      .axs_s0_awvalid(s0_awvalid), .axs_s0_awready(s0_awready),
      .axs_s0_wdata(s0_wdata), .axs_s0_wid(s0_wid), .axs_s0_wlast(s0_wlast),
      .axs_s0_wstrb(s0_wstrb), .axs_s0_wvalid(s0_wvalid), .axs_s0_wready(s0_wready),
      .axs_s0_rdata(s0_rdata), .axs_s0_rid(s0_rid), .axs_s0_rlast(s0_rlast),
      .axs_s0_rresp(s0_rresp), .axs_s0_rvalid(s0_rvalid), .axs_s0_rready(s0_rready),
      .axs_s0_bid(s0_bid), .axs_s0_bresp(s0_bresp), .axs_s0_bvalid(s0_bvalid),
      .axs_s0_bready(s0_bready),
      .axm_m0_araddr(m0_araddr), .axm_m0_arburst(m0_arburst), .axm_m0_arcache(m0_arcache),
      .axm_m0_arid(m0_arid), .axm_m0_arlen(m0_arlen), .axm_m0_arlock(m0_arlock),
      .axm_m0_arprot(m0_arprot), .axm_m0_arsize(m0_arsize), .axm_m0_aruser(m0_aruser),
      .axm_m0_arvalid(m0_arvalid), .axm_m0_arready(m0_arready),
      .axm_m0_awaddr(m0_awaddr), .axm_m0_awburst(m0_awburst), .axm_m0_awcache(m0_awcache),
      .axm_m0_awid(m0_awid), .axm_m0_awlen(m0_awlen), .axm_m0_awlock(m0_awlock),
      .axm_m0_awprot(m0_awprot), .axm_m0_awsize(m0_awsize), .axm_m0_awuser(m0_awuser),
      .axm_m0_awvalid(m0_awvalid), .axm_m0_awready(m0_awready),
      .axm_m0_wdata(m0_wdata), .axm_m0_wid(m0_wid), .axm_m0_wlast(m0_wlast),
      .axm_m0_wstrb(m0_wstrb), .axm_m0_wvalid(m0_wvalid), .axm_m0_wready(m0_wready),
      .axm_m0_rdata(m0_rdata), .axm_m0_rid(m0_rid), .axm_m0_rlast(m0_rlast),
      .axm_m0_rresp(m0_rresp), .axm_m0_rvalid(m0_rvalid), .axm_m0_rready(m0_rready),
      .axm_m0_bid(m0_bid), .axm_m0_bresp(m0_bresp), .axm_m0_bvalid(m0_bvalid),
      .axm_m0_bready(m0_bready),
      .rd_outstanding(rd_out), .wr_outstanding(wr_out), .idle(idle), .protocol_err(perr)
   );

   // ---------------- pass-through build (OVERRIDE_EN=0, 64-bit) ----------------
   logic [31:0] b_s0_araddr, b_m0_araddr, b_s0_awaddr, b_m0_awaddr;
   logic [1:0]  b_s0_arburst, b_m0_arburst, b_s0_awburst, b_m0_awburst;
   logic [3:0]  b_s0_arcache, b_m0_arcache, b_s0_awcache, b_m0_awcache;
   logic [7:0]  b_s0_arid, b_m0_arid, b_s0_awid, b_m0_awid;
   logic [3:0]  b_s0_arlen, b_m0_arlen, b_s0_awlen, b_m0_awlen;
   logic [1:0]  b_s0_arlock, b_m0_arlock, b_s0_awlock, b_m0_awlock;
   logic [2:0]  b_s0_arprot, b_m0_arprot, b_s0_awprot, b_m0_awprot;
   logic [2:0]  b_s0_arsize, b_m0_arsize, b_s0_awsize, b_m0_awsize;
   logic [4:0]  b_s0_aruser, b_m0_aruser, b_s0_awuser, b_m0_awuser;
   logic        b_s0_arvalid, b_s0_arready, b_m0_arvalid, b_m0_arready;
   logic        b_s0_awvalid, b_s0_awready, b_m0_awvalid, b_m0_awready;
   logic [63:0] b_s0_wdata, b_m0_wdata, b_s0_rdata, b_m0_rdata;
   logic [7:0]  b_s0_wstrb, b_m0_wstrb;
   logic [7:0]  b_s0_wid, b_m0_wid, b_s0_rid, b_m0_rid, b_s0_bid, b_m0_bid;
   logic        b_s0_wlast, b_m0_wlast, b_s0_wvalid, b_m0_wvalid, b_s0_wready, b_m0_wready;
   logic        b_s0_rlast, b_m0_rlast, b_s0_rvalid, b_m0_rvalid, b_s0_rready, b_m0_rready;
   logic [1:0]  b_s0_rresp, b_m0_rresp, b_s0_bresp, b_m0_bresp;
   logic        b_s0_bvalid, b_m0_bvalid, b_s0_bready, b_m0_bready;
   logic [3:0]  b_rd_out, b_wr_out;
   logic        b_idle;
   logic [1:0]  b_perr;

   axi_acp_bridge_pipelined #(.DATA_WIDTH(64), .OVERRIDE_EN(1'b0)) dut64 (
      .clk(clk), .reset(reset),
      .axs_s0_araddr(b_s0_araddr), .axs_s0_arburst(b_s0_arburst), .axs_s0_arcache(b_s0_arcache),
      .axs_s0_arid(b_s0_arid), .axs_s0_arlen(b_s0_arlen), .axs_s0_arlock(b_s0_arlock),
      .axs_s0_arprot(b_s0_arprot), .axs_s0_arsize(b_s0_arsize), .axs_s0_aruser(b_s0_aruser),
      .axs_s0_arvalid(b_s0_arvalid), .axs_s0_arready(b_s0_arready),
      .axs_s0_awaddr(b_s0_awaddr), .axs_s0_awburst(b_s0_awburst), .axs_s0_awcache(b_s0_awcache),
      .axs_s0_awid(b_s0_awid), .axs_s0_awlen(b_s0_awlen), .axs_s0_awlock(b_s0_awlock),
      .axs_s0_awprot(b_s0_awprot), .axs_s0_awsize(b_s0_awsize), .axs_s0_awuser(b_s0_awuser),
      .axs_s0_awvalid(b_s0_awvalid), .axs_s0_awready(b_s0_awready),
      .axs_s0_wdata(b_s0_wdata), .axs_s0_wid(b_s0_wid), .axs_s0_wlast(b_s0_wlast),
      .axs_s0_wstrb(b_s0_wstrb), .axs_s0_wvalid(b_s0_wvalid), .axs_s0_wready(b_s0_wready),
      .axs_s0_rdata(b_s0_rdata), .axs_s0_rid(b_s0_rid), .axs_s0_rlast(b_s0_rlast),
      .axs_s0_rresp(b_s0_rresp), .axs_s0_rvalid(b_s0_rvalid), .axs_s0_rready(b_s0_rready),
      .axs_s0_bid(b_s0_bid), .axs_s0_bresp(b_s0_bresp), .axs_s0_bvalid(b_s0_bvalid),
      .axs_s0_bready(b_s0_bready),
      .axm_m0_araddr(b_m0_araddr), .axm_m0_arburst(b_m0_arburst), .axm_m0_arcache(b_m0_arcache),
      .axm_m0_arid(b_m0_arid), .axm_m0_arlen(b_m0_arlen), .axm_m0_arlock(b_m0_arlock),
      .axm_m0_arprot(b_m0_arprot), .axm_m0_arsize(b_m0_arsize), .axm_m0_aruser(b_m0_aruser),
      .axm_m0_arvalid(b_m0_arvalid), .axm_m0_arready(b_m0_arready),
      .axm_m0_awaddr(b_m0_awaddr), .axm_m0_awburst(b_m0_awburst), .axm_m0_awcache(b_m0_awcache),
      .axm_m0_awid(b_m0_awid), .axm_m0_awlen(b_m0_awlen), .axm_m0_awlock(b_m0_awlock),
      .axm_m0_awprot(b_m0_awprot), .axm_m0_awsize(b_m0_awsize), .axm_m0_awuser(b_m0_awuser),
      .axm_m0_awvalid(b_m0_awvalid), .axm_m0_awready(b_m0_awready),
      .axm_m0_wdata(b_m0_wdata), .axm_m0_wid(b_m0_wid), .axm_m0_wlast(b_m0_wlast),
      .axm_m0_wstrb(b_m0_wstrb), .axm_m0_wvalid(b_m0_wvalid), .axm_m0_wready(b_m0_wready),
      .axm_m0_rdata(b_m0_rdata), .axm_m0_rid(b_m0_rid), .axm_m0_rlast(b_m0_rlast),
      .axm_m0_rresp(b_m0_rresp), .axm_m0_rvalid(b_m0_rvalid), .axm_m0_rready(b_m0_rready),
      .axm_m0_bid(b_m0_bid), .axm_m0_bresp(b_m0_bresp), .axm_m0_bvalid(b_m0_bvalid),
      .axm_m0_bready(b_m0_bready),
      .rd_outstanding(b_rd_out), .wr_outstanding(b_wr_out), .idle(b_idle), .protocol_err(b_perr)
   );

   // ---------------- behavioural model of the default build ----------------
   typedef struct {
      logic [31:0] addr; logic [1:0] burst; logic [3:0] cache; logic [7:0] id;
      logic [3:0] len; logic [1:0] lock; logic [2:0] prot; logic [2:0] size; logic [4:0] user;
   } cmd_t;

   cmd_t ar_q[$], aw_q[$];
   int   mdl_rd = 0, mdl_wr = 0;
   logic [1:0] mdl_err = 2'b00;

   always @(negedge clk) begin
      if (reset) begin
         ar_q.delete(); aw_q.delete();
         mdl_rd = 0; mdl_wr = 0; mdl_err = 2'b00;
      end else begin
         bit ar_v, aw_v, ar_push, aw_push, ar_pop, aw_pop, r_dec, b_dec;
         ar_v = (ar_q.size() > 0) && (mdl_rd < MAX_RD);
         aw_v = (aw_q.size() > 0) && (mdl_wr < MAX_WR);
         chk("m0_arvalid", m0_arvalid, ar_v);
         chk("m0_awvalid", m0_awvalid, aw_v);
         chk("s0_arready", s0_arready, ar_q.size() < 2);
         chk("s0_awready", s0_awready, aw_q.size() < 2);
         if (ar_v) begin
            chk("m0_ar_fields", {m0_araddr, m0_arburst, m0_arid, m0_arlen, m0_arlock, m0_arsize},
                {ar_q[0].addr, ar_q[0].burst, ar_q[0].id, ar_q[0].len, ar_q[0].lock, ar_q[0].size});
            chk("m0_ar_cond", {m0_arcache, m0_arprot, m0_aruser}, {4'hF, 3'b000, 5'b00001});
         end
         if (aw_v) begin
            chk("m0_aw_fields", {m0_awaddr, m0_awburst, m0_awid, m0_awlen, m0_awlock, m0_awsize},
                {aw_q[0].addr, aw_q[0].burst, aw_q[0].id, aw_q[0].len, aw_q[0].lock, aw_q[0].size});
            chk("m0_aw_cond", {m0_awcache, m0_awprot, m0_awuser}, {4'hF, 3'b000, 5'b00001});
         end
         chk("rd_outstanding", rd_out, mdl_rd);
         chk("wr_outstanding", wr_out, mdl_wr);
         chk("protocol_err", perr, mdl_err);
         chk("idle", idle, ar_q.size() == 0 && aw_q.size() == 0 && mdl_rd == 0 && mdl_wr == 0);
         chk("w_pass", {m0_wdata, m0_wstrb, m0_wid, m0_wlast, m0_wvalid, s0_wready},
             {s0_wdata, s0_wstrb, s0_wid, s0_wlast, s0_wvalid, m0_wready});
         chk("r_pass", {s0_rdata, s0_rid, s0_rresp, s0_rlast, s0_rvalid, m0_rready},
             {m0_rdata, m0_rid, m0_rresp, m0_rlast, m0_rvalid, s0_rready});
         chk("b_pass", {s0_bid, s0_bresp, s0_bvalid, m0_bready},
             {m0_bid, m0_bresp, m0_bvalid, s0_bready});

         // advance to what the coming clock edge commits
         ar_push = s0_arvalid && ar_q.size() < 2;
         aw_push = s0_awvalid && aw_q.size() < 2;
         ar_pop  = ar_v && m0_arready;
         aw_pop  = aw_v && m0_awready;
         r_dec   = m0_rvalid && s0_rready && m0_rlast;
         b_dec   = m0_bvalid && s0_bready;
         if (ar_pop) void'(ar_q.pop_front());
         if (aw_pop) void'(aw_q.pop_front());
         if (ar_push) ar_q.push_back('{s0_araddr, s0_arburst, s0_arcache, s0_arid, s0_arlen,
                                       s0_arlock, s0_arprot, s0_arsize, s0_aruser});
         if (aw_push) aw_q.push_back('{s0_awaddr, s0_awburst, s0_awcache, s0_awid, s0_awlen,
                                       s0_awlock, s0_awprot, s0_awsize, s0_awuser});
         if (r_dec && mdl_rd == 0) mdl_err[0] = 1'b1;
         if (b_dec && mdl_wr == 0) mdl_err[1] = 1'b1;
         mdl_rd = mdl_rd + int'(ar_pop) - int'(r_dec && mdl_rd != 0);
         mdl_wr = mdl_wr + int'(aw_pop) - int'(b_dec && mdl_wr != 0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_ar(input logic [31:0] addr, input logic [7:0] id);
      s0_araddr = addr; s0_arid = id; s0_arlen = id[3:0]; s0_arcache = 4'b0000;
      s0_aruser = 5'd0; s0_arprot = 3'b010; s0_arvalid = 1'b1;
      for (int n = 0; n < 40 && !s0_arready; n++) tick();
      if (!s0_arready) chk("ar_accept_timeout", 1'b0, 1'b1);
      tick();
      s0_arvalid = 1'b0;
      $display("AR issued addr=%08h id=%02h", addr, id);
   endtask

   task automatic send_aw(input logic [31:0] addr, input logic [7:0] id);
      s0_awaddr = addr; s0_awid = id; s0_awlen = 4'd1; s0_awcache = 4'b0011;
      s0_awuser = 5'h1F; s0_awprot = 3'b101; s0_awvalid = 1'b1;
      for (int n = 0; n < 40 && !s0_awready; n++) tick();
      if (!s0_awready) chk("aw_accept_timeout", 1'b0, 1'b1);
      tick();
      s0_awvalid = 1'b0;
      $display("AW issued addr=%08h id=%02h", addr, id);
   endtask

   task automatic pulse_r(input int cycles);
      m0_rvalid = 1'b1; m0_rlast = 1'b1; m0_rdata = {4{32'hCAFE_0000 + 32'(cycles)}};
      repeat (cycles) tick();
      m0_rvalid = 1'b0; m0_rlast = 1'b0;
      $display("R last beats: %0d", cycles);
   endtask

   task automatic pulse_b(input int cycles);
      m0_bvalid = 1'b1; m0_bid = 8'h21; m0_bresp = 2'b00;
      repeat (cycles) tick();
      m0_bvalid = 1'b0;
      $display("B responses: %0d", cycles);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      {s0_araddr, s0_arburst, s0_arcache, s0_arid, s0_arlen, s0_arlock, s0_arprot, s0_arsize,
       s0_aruser, s0_arvalid} = '0;
      {s0_awaddr, s0_awburst, s0_awcache, s0_awid, s0_awlen, s0_awlock, s0_awprot, s0_awsize,
       s0_awuser, s0_awvalid} = '0;
      s0_arburst = 2'b01; s0_arsize = 3'd4; s0_awburst = 2'b01; s0_awsize = 3'd4;
      {s0_wdata, s0_wid, s0_wlast, s0_wstrb, s0_wvalid} = '0;
      {m0_rdata, m0_rid, m0_rlast, m0_rresp, m0_rvalid, m0_bid, m0_bresp, m0_bvalid} = '0;
      m0_arready = 1'b1; m0_awready = 1'b1; m0_wready = 1'b1; s0_rready = 1'b1; s0_bready = 1'b1;
      {b_s0_araddr, b_s0_arburst, b_s0_arcache, b_s0_arid, b_s0_arlen, b_s0_arlock, b_s0_arprot,
       b_s0_arsize, b_s0_aruser, b_s0_arvalid} = '0;
      {b_s0_awaddr, b_s0_awburst, b_s0_awcache, b_s0_awid, b_s0_awlen, b_s0_awlock, b_s0_awprot,
       b_s0_awsize, b_s0_awuser, b_s0_awvalid} = '0;
      {b_s0_wdata, b_s0_wid, b_s0_wlast, b_s0_wstrb, b_s0_wvalid} = '0;
      {b_m0_rdata, b_m0_rid, b_m0_rlast, b_m0_rresp, b_m0_rvalid, b_m0_bid, b_m0_bresp,
       b_m0_bvalid} = '0;
      b_m0_arready = 1'b1; b_m0_awready = 1'b0; b_m0_wready = 1'b1;
      b_s0_rready = 1'b1; b_s0_bready = 1'b1;

      repeat (3) tick();
      reset = 1'b0;
      chk("reset_state", {m0_arvalid, m0_awvalid, s0_arready, s0_awready, idle, rd_out, wr_out, perr},
          {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00});
      $display("reset released");

      // single read with conditioning
      tick();
      s0_araddr = 32'h0000_1000; s0_arid = 8'h05; s0_arcache = 4'b0000; s0_aruser = 5'd0;
      s0_arprot = 3'b010; s0_arlen = 4'd3; s0_arvalid = 1'b1;
      #1 chk("ar_before_hs", m0_arvalid, 1'b0);
      tick();
      s0_arvalid = 1'b0;
      chk("ar_latency1", {m0_arvalid, m0_araddr, m0_arcache, m0_arprot, m0_aruser, m0_arid, m0_arlen},
          {1'b1, 32'h0000_1000, 4'b1111, 3'b000, 5'b00001, 8'h05, 4'd3});
      $display("AR single addr=00001000 id=05");
      tick();
      chk("rd_out_one", rd_out, 4'd1);
      m0_rid = 8'h05;
      pulse_r(1);
      chk("rd_out_back0", rd_out, 4'd0);

      // outstanding limit: six back-to-back reads with R held off
      for (int i = 0; i < 6; i++) send_ar(32'h0000_2000 + 32'(i) * 32'h40, 8'(8'h10 + i));
      chk("limit_state", {rd_out, m0_arvalid, s0_arready}, {4'd4, 1'b0, 1'b0});
      pulse_r(1);
      chk("release_one", {rd_out, m0_arvalid, m0_araddr}, {4'd3, 1'b1, 32'h0000_2100});
      tick();
      chk("released_state", {rd_out, m0_arvalid, s0_arready}, {4'd4, 1'b0, 1'b1});
      pulse_r(5);
      repeat (2) tick();
      chk("drained_rd", {rd_out, idle, perr}, {4'd0, 1'b1, 2'b00});

      // AW stall with W flowing independently
      m0_awready = 1'b0;
      s0_wdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; s0_wstrb = 16'hF0F0;
      s0_wid = 8'h31; s0_wlast = 1'b1; s0_wvalid = 1'b1;
      send_aw(32'h0000_3000, 8'h31);
      send_aw(32'h0000_3040, 8'h32);
      s0_awaddr = 32'h0000_3080; s0_awid = 8'h33; s0_awvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("aw_stall", {m0_awvalid, m0_awaddr, m0_awid, m0_awcache, m0_awuser, s0_awready},
             {1'b1, 32'h0000_3000, 8'h31, 4'b1111, 5'b00001, 1'b0});
         tick();
      end
      s0_awvalid = 1'b0;
      m0_awready = 1'b1;
      send_aw(32'h0000_3080, 8'h33);
      s0_wvalid = 1'b0;
      repeat (4) tick();
      chk("wr_out_three", wr_out, 4'd3);

      // simultaneous AW and B handshakes at a count of 2
      pulse_b(1);
      chk("wr_out_two", wr_out, 4'd2);
      m0_awready = 1'b0;
      send_aw(32'h0000_3100, 8'h34);
      m0_awready = 1'b1; m0_bvalid = 1'b1;
      tick();
      m0_bvalid = 1'b0;
      chk("wr_simul", {wr_out, m0_awvalid}, {4'd2, 1'b0});
      $display("AW+B same cycle, wr_outstanding=%0d", wr_out);
      pulse_b(2);
      chk("wr_out_zero", wr_out, 4'd0);

      // unsolicited B
      pulse_b(1);
      chk("unsolicited_b", {wr_out, perr}, {4'd0, 2'b10});
      repeat (5) tick();
      chk("err_sticky", perr, 2'b10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("err_cleared", {perr, idle}, {2'b00, 1'b1});
      $display("reset cleared protocol_err");

      // pass-through build
      b_m0_awready = 1'b1;
      b_s0_awaddr = 32'h0000_4000; b_s0_awid = 8'h44; b_s0_awcache = 4'b0011;
      b_s0_awuser = 5'h1F; b_s0_awprot = 3'b101; b_s0_awlen = 4'd7; b_s0_awvalid = 1'b1;
      b_s0_wdata = 64'h0123_4567_89AB_CDEF; b_s0_wstrb = 8'hA5; b_s0_wid = 8'h44;
      b_s0_wlast = 1'b1; b_s0_wvalid = 1'b1;
      #1 chk("b_aw_ready", b_s0_awready, 1'b1);
      chk("b_w_pass", {b_m0_wdata, b_m0_wstrb, b_m0_wvalid},
          {64'h0123_4567_89AB_CDEF, 8'hA5, 1'b1});
      tick();
      b_s0_awvalid = 1'b0; b_s0_wvalid = 1'b0;
      chk("b_aw_fields", {b_m0_awvalid, b_m0_awaddr, b_m0_awcache, b_m0_awuser, b_m0_awprot, b_m0_awlen},
          {1'b1, 32'h0000_4000, 4'b0011, 5'h1F, 3'b101, 4'd7});
      $display("64-bit AW addr=00004000 cache=%h user=%h", b_m0_awcache, b_m0_awuser);
      tick();
      chk("b_wr_out", b_wr_out, 4'd1);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_acp_bridge_pipelined.md
Name: axi_acp_bridge_pipelined

Overview:
- Parametrised AXI3 bridge between a fabric master (s0) and the HPS F2S bridge (m0), for accesses that target the Cortex-A9 ACP.
- Conditions the AxCACHE, AxPROT and AxUSER fields, as the current fixed 128-bit bridge does.
- Adds a registered 2-entry skid buffer on the AR and AW channels.
- Adds per-direction outstanding-transaction limiting, so the ACP is never oversubscribed.
- Adds status and sticky protocol-error reporting.

Parameters:
- DATA_WIDTH, 128: W and R data width; legal values 32, 64, 128. Strobe width is DATA_WIDTH/8.
- ADDR_WIDTH, 32: AR and AW address width.
- ID_WIDTH, 8: AXI ID width on all channels.
- USER_WIDTH, 5: AxUSER width.
- OVERRIDE_EN, 1: 1 drives the constant fields below onto m0; 0 passes the s0 values through unchanged.
- AXCACHE_VAL, 4'b1111: m0 arcache/awcache value when OVERRIDE_EN=1.
- AXPROT_VAL, 3'b000: m0 arprot/awprot value when OVERRIDE_EN=1.
- AXUSER_VAL, 5'b00001: m0 aruser/awuser value when OVERRIDE_EN=1.
- MAX_RD, 4: maximum outstanding reads, range 1..15.
- MAX_WR, 4: maximum outstanding writes, range 1..15.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- axs_s0_ar{addr,burst,cache,id,len,lock,prot,size,user,valid} / axs_s0_arready: slave AR channel. Widths: ADDR_WIDTH, 2, 4, ID_WIDTH, 4, 2, 3, 3, USER_WIDTH, 1 / out 1.
- axs_s0_aw{...} / axs_s0_awready: slave AW channel, same field set and widths as AR.
- axs_s0_w{data,id,last,strb,valid} / axs_s0_wready: slave W channel. Widths: DATA_WIDTH, ID_WIDTH, 1, DATA_WIDTH/8, 1.
- axs_s0_r{data,id,last,resp,valid} / axs_s0_rready: slave R channel (out / in).
- axs_s0_b{id,resp,valid} / axs_s0_bready: slave B channel (out / in).
- axm_m0_ar*, axm_m0_aw*, axm_m0_w*, axm_m0_r*, axm_m0_b*: master-side mirror of every slave port, directions inverted.
- rd_outstanding, out, 4: current count of outstanding reads.
- wr_outstanding, out, 4: current count of outstanding writes.
- idle, out, 1: high when both skid buffers are empty and both outstanding counts are 0.
- protocol_err, out, 2: sticky. Bit 0 = R-last received with no read outstanding; bit 1 = B received with no write outstanding.

Behaviour:
- Reset (asynchronous, active-high) values:
  - axm_m0_arvalid = 0, axm_m0_awvalid = 0.
  - axs_s0_arready = 1, axs_s0_awready = 1.
  - Both skid buffers empty; both counters 0; protocol_err = 0; idle = 1.
- Reset mid-burst discards all buffered commands and counts; no transaction replay.
- AR and AW skid buffers (identical, independent):
  - Entry width covers all command fields.
  - axs_s0_xready is registered and equals "buffer holds fewer than 2 entries".
  - s0 handshake writes an entry. The head is presented on m0 from the next cycle, giving 1-cycle latency.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Order is strict FIFO; no combinational path from m0 ready to s0 ready.
  - m0 cache/prot/user come from the parameters when OVERRIDE_EN=1, otherwise from the buffered s0 values. All other fields pass through unchanged.
- Gating:
  - axm_m0_arvalid = buffer non-empty AND rd_outstanding < MAX_RD.
  - axm_m0_awvalid = buffer non-empty AND wr_outstanding < MAX_WR.
  - Counts only increase via the gated channel's own handshake, so an asserted valid never drops before ready.
- Counters:
  - rd_outstanding: +1 on m0 AR handshake; -1 on m0 R handshake with rlast=1.
  - wr_outstanding: +1 on m0 AW handshake; -1 on m0 B handshake.
  - Simultaneous increment and decrement leaves the count unchanged.
  - A decrement at 0 saturates at 0 and sets the matching protocol_err bit. Only reset clears protocol_err.
- W, R and B channels are combinational pass-through, including valid/ready, with zero latency. W is not gated by the AW count; the HPS accepts W-before-AW.
- idle is combinational from registered state.

Test Plan:
- Reset, then a single AR (addr 0x0000_1000, arcache 0000, aruser 0, id 0x05) → m0 arvalid rises exactly 1 cycle after the s0 handshake with arcache=1111, arprot=000, aruser=00001, id=0x05. rd_outstanding becomes 1, then returns to 0 after R with rlast.
- MAX_RD=4, m0 holds R off, 6 back-to-back ARs → 4 issue on m0. The 5th waits in the buffer with arvalid low; the 6th fills the buffer and arready drops. One rlast releases exactly one more AR.
- m0 awready held low for 10 cycles with awvalid high → awvalid and all aw fields stay stable; s0 awready = 0 after 2 accepted commands.
- Same-cycle m0 AW handshake and B handshake at wr_outstanding=2 → count stays 2.
- Unsolicited B with wr_outstanding=0 → count stays 0 and protocol_err = 2'b10 persists until reset.
- OVERRIDE_EN=0, DATA_WIDTH=64 build: awcache=0011, awuser=0x1F → values reach m0 unchanged, and 64-bit write data and 8-bit strobe pass through intact.
